// File: rtl/post_add_acc_if.sv
// Operand, control and result bundle for the DSP48A1 post-adder/accumulator stage.
// Clock and reset stay plain ports on the block.
interface post_add_acc_if #(
  parameter int WIDTH_P = 48,
  parameter int WIDTH_M = 36
);
  logic               CEP;
  logic               CEOPMODE;
  logic [4:0]         OPMODE;
  logic [WIDTH_M-1:0] M;
  logic [WIDTH_P-1:0] C;
  logic [WIDTH_P-1:0] DAB;
  logic [WIDTH_P-1:0] PCIN;
  logic               CIN;
  logic [WIDTH_P-1:0] P;
  logic [WIDTH_P-1:0] PCOUT;
  logic               CARRYOUT;
  logic               CARRYOUTF;

  modport master (
    output CEP, CEOPMODE, OPMODE, M, C, DAB, PCIN, CIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  CEP, CEOPMODE, OPMODE, M, C, DAB, PCIN, CIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF
  );
endinterface

// File: rtl/post_add_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand muxes, add/sub with carry-in,
// optional P, carry-out and OPMODE registers, and P feedback for accumulation.
module post_add_acc #(
  parameter int WIDTH_P     = 48,
  parameter int WIDTH_M     = 36,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int OPMODEREG   = 1
) (
  input logic          CLK,
  input logic          rst_n,
  post_add_acc_if.slave bus
);

   logic [4:0]         opm;
   logic [WIDTH_P-1:0] p_fb;
   logic [WIDTH_P-1:0] x_sel;
   logic [WIDTH_P-1:0] z_sel;
   logic [WIDTH_P:0]   x_cin;
   logic [WIDTH_P:0]   sum;
   logic [WIDTH_P-1:0] result;
   logic               co;
   logic [WIDTH_P-1:0] p_out;
   logic               co_out;

   generate
      if (OPMODEREG != 0) begin : g_opm_reg
         logic [4:0] opmode_reg;
         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n)            opmode_reg <= '0;
            else if (bus.CEOPMODE) opmode_reg <= bus.OPMODE;
         end
         assign opm = opmode_reg;
      end else begin : g_opm_comb
         assign opm = bus.OPMODE;
      end
   endgenerate

   always_comb begin
      x_sel = '0;
      case (opm[1:0])
         2'd0: x_sel = '0;
         2'd1: x_sel = WIDTH_P'(bus.M);
         2'd2: x_sel = p_fb;
         2'd3: x_sel = bus.DAB;
         default: x_sel = '0;
      endcase
   end

   always_comb begin
      z_sel = '0;
      case (opm[3:2])
         2'd0: z_sel = '0;
         2'd1: z_sel = bus.PCIN;
         2'd2: z_sel = p_fb;
         2'd3: z_sel = bus.C;
         default: z_sel = '0;
      endcase
   end

   // X+CIN cannot overflow WIDTH_P+1 bits, so the top bit of the
   // difference is exactly the borrow (Z < X+CIN).
   always_comb begin
      x_cin = {1'b0, x_sel} + {{WIDTH_P{1'b0}}, bus.CIN};
      if (opm[4]) sum = {1'b0, z_sel} - x_cin;
      else        sum = {1'b0, z_sel} + x_cin;
   end

   assign result = sum[WIDTH_P-1:0];
   assign co     = sum[WIDTH_P];

   // Without the P register there is no feedback path; select 2 reads zero.
   generate
      if (PREG != 0) begin : g_preg
         logic [WIDTH_P-1:0] p_reg;
         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n)       p_reg <= '0;
            else if (bus.CEP) p_reg <= result;
         end
         assign p_fb  = p_reg;
         assign p_out = p_reg;
      end else begin : g_pcomb
         assign p_fb  = '0;
         assign p_out = result;
      end
   endgenerate

   generate
      if (CARRYOUTREG != 0) begin : g_coreg
         logic carryout_reg;
         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n)       carryout_reg <= 1'b0;
            else if (bus.CEP) carryout_reg <= co;
         end
         assign co_out = carryout_reg;
      end else begin : g_cocomb
         assign co_out = co;
      end
   endgenerate

   assign bus.P         = p_out;
   assign bus.PCOUT     = p_out;
   assign bus.CARRYOUT  = co_out;
   assign bus.CARRYOUTF = co_out;

endmodule

// File: tb/tb_post_add_acc.sv
// Directed bench for post_add_acc: registered instance (all regs on) and a
// fully combinational instance for the cascade / no-feedback case.
module tb_post_add_acc;

   localparam int WP = 48;
   localparam int WM = 36;
   localparam logic [WP-1:0] ONES = {WP{1'b1}};

   logic CLK = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   post_add_acc_if #(.WIDTH_P(WP), .WIDTH_M(WM)) bus0 ();
   post_add_acc_if #(.WIDTH_P(WP), .WIDTH_M(WM)) bus1 ();

   post_add_acc #(.WIDTH_P(WP), .WIDTH_M(WM), .PREG(1), .CARRYOUTREG(1), .OPMODEREG(1))
      u_reg (.CLK(CLK), .rst_n(rst_n), .bus(bus0.slave));

   post_add_acc #(.WIDTH_P(WP), .WIDTH_M(WM), .PREG(0), .CARRYOUTREG(0), .OPMODEREG(0))
      u_comb (.CLK(CLK), .rst_n(rst_n), .bus(bus1.slave));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus0.CEP = 1'b1; bus0.CEOPMODE = 1'b1; bus0.OPMODE = 5'b00000;
      bus0.M = '0; bus0.C = '0; bus0.DAB = '0; bus0.PCIN = '0; bus0.CIN = 1'b0;
      bus1.CEP = 1'b1; bus1.CEOPMODE = 1'b1; bus1.OPMODE = 5'b00000;
      bus1.M = '0; bus1.C = '0; bus1.DAB = '0; bus1.PCIN = '0; bus1.CIN = 1'b0;
      #3;
      checks++; if (bus0.P !== '0) begin errors++; $display("FAIL rst_p got %h exp 0", bus0.P); end
      checks++; if (bus0.PCOUT !== '0) begin errors++; $display("FAIL rst_pcout got %h exp 0", bus0.PCOUT); end
      checks++; if (bus0.CARRYOUT !== 1'b0) begin errors++; $display("FAIL rst_co got %b exp 0", bus0.CARRYOUT); end
      checks++; if (bus0.CARRYOUTF !== 1'b0) begin errors++; $display("FAIL rst_cof got %b exp 0", bus0.CARRYOUTF); end
      @(negedge CLK);
      rst_n = 1'b1;
      // preload 0x1234 via Z=C
      bus0.OPMODE = 5'b01100; bus0.C = 48'h1234;
      tick(2);
      checks++; if (bus0.P !== 48'h1234) begin errors++; $display("FAIL preload_1234 got %h exp 1234", bus0.P); end
      // asynchronous mid-cycle reset
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus0.P !== '0) begin errors++; $display("FAIL async_rst_p got %h exp 0", bus0.P); end
      checks++; if (bus0.PCOUT !== '0) begin errors++; $display("FAIL async_rst_pcout got %h exp 0", bus0.PCOUT); end
      checks++; if (bus0.CARRYOUT !== 1'b0) begin errors++; $display("FAIL async_rst_co got %b exp 0", bus0.CARRYOUT); end
      #1 rst_n = 1'b1;
      // OPMODE reg was cleared too, so the first edge computes 0+0+CIN
      bus0.CIN = 1'b1;
      tick(1);
      checks++; if (bus0.P !== 48'h1) begin errors++; $display("FAIL post_rst_load got %h exp 1", bus0.P); end
   endtask

   task automatic test_add;
      bus0.OPMODE = 5'b01101; bus0.M = 36'd5; bus0.C = 48'd10; bus0.CIN = 1'b1;
      tick(1);  // old opmode Z=C,X=0: 10+1
      checks++; if (bus0.P !== 48'd11) begin errors++; $display("FAIL add_latency got %h exp b", bus0.P); end
      tick(1);
      checks++; if (bus0.P !== 48'd16) begin errors++; $display("FAIL add_p got %h exp 10", bus0.P); end
      checks++; if (bus0.CARRYOUT !== 1'b0) begin errors++; $display("FAIL add_co got %b exp 0", bus0.CARRYOUT); end
      checks++; if (bus0.CARRYOUTF !== 1'b0) begin errors++; $display("FAIL add_cof got %b exp 0", bus0.CARRYOUTF); end
   endtask

   task automatic test_sub_borrow;
      bus0.OPMODE = 5'b11101; bus0.C = 48'd3; bus0.M = 36'd5; bus0.CIN = 1'b0;
      tick(1);  // still adding: 3+5
      checks++; if (bus0.P !== 48'd8) begin errors++; $display("FAIL sub_latency got %h exp 8", bus0.P); end
      tick(1);
      checks++; if (bus0.P !== 48'hFFFFFFFFFFFE) begin errors++; $display("FAIL sub_p got %h exp fffffffffffe", bus0.P); end
      checks++; if (bus0.CARRYOUT !== 1'b1) begin errors++; $display("FAIL sub_borrow got %b exp 1", bus0.CARRYOUT); end
      checks++; if (bus0.CARRYOUTF !== 1'b1) begin errors++; $display("FAIL sub_borrowf got %b exp 1", bus0.CARRYOUTF); end
      checks++; if (bus0.PCOUT !== 48'hFFFFFFFFFFFE) begin errors++; $display("FAIL sub_pcout got %h exp fffffffffffe", bus0.PCOUT); end
   endtask

   task automatic test_accumulate;
      bus0.OPMODE = 5'b01100; bus0.C = ONES; bus0.CIN = 1'b0;
      tick(2);
      checks++; if (bus0.P !== ONES) begin errors++; $display("FAIL acc_preload got %h exp %h", bus0.P, ONES); end
      checks++; if (bus0.CARRYOUT !== 1'b0) begin errors++; $display("FAIL acc_preload_co got %b exp 0", bus0.CARRYOUT); end
      bus0.OPMODE = 5'b01001; bus0.M = 36'd1;
      tick(1);  // opmode being captured, still loading C
      checks++; if (bus0.P !== ONES) begin errors++; $display("FAIL acc_capture got %h exp %h", bus0.P, ONES); end
      tick(1);
      checks++; if (bus0.P !== '0) begin errors++; $display("FAIL acc_wrap_p got %h exp 0", bus0.P); end
      checks++; if (bus0.CARRYOUT !== 1'b1) begin errors++; $display("FAIL acc_wrap_co got %b exp 1", bus0.CARRYOUT); end
      tick(1);
      checks++; if (bus0.P !== 48'd1) begin errors++; $display("FAIL acc_step_p got %h exp 1", bus0.P); end
      checks++; if (bus0.CARRYOUT !== 1'b0) begin errors++; $display("FAIL acc_step_co got %b exp 0", bus0.CARRYOUT); end
      bus0.CEP = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++; if (bus0.P !== 48'd1) begin errors++; $display("FAIL acc_hold%0d got %h exp 1", i, bus0.P); end
      end
      checks++; if (bus0.CARRYOUT !== 1'b0) begin errors++; $display("FAIL acc_hold_co got %b exp 0", bus0.CARRYOUT); end
      bus0.CEP = 1'b1;
   endtask

   task automatic test_opmode_latency;
      bus0.OPMODE = 5'b00011; bus0.DAB = 48'd7; bus0.M = 36'd1;
      tick(1);  // last accumulate: 1+1
      checks++; if (bus0.P !== 48'd2) begin errors++; $display("FAIL opm_prev got %h exp 2", bus0.P); end
      tick(1);
      checks++; if (bus0.P !== 48'd7) begin errors++; $display("FAIL opm_dab got %h exp 7", bus0.P); end
      bus0.OPMODE = 5'b00000;
      tick(1);
      checks++; if (bus0.P !== 48'd7) begin errors++; $display("FAIL opm_delay got %h exp 7", bus0.P); end
      tick(1);
      checks++; if (bus0.P !== '0) begin errors++; $display("FAIL opm_zero got %h exp 0", bus0.P); end
      bus0.OPMODE = 5'b00011;
      tick(2);
      checks++; if (bus0.P !== 48'd7) begin errors++; $display("FAIL opm_restore got %h exp 7", bus0.P); end
      bus0.CEOPMODE = 1'b0; bus0.OPMODE = 5'b00000;
      tick(2);
      checks++; if (bus0.P !== 48'd7) begin errors++; $display("FAIL opm_ce_hold got %h exp 7", bus0.P); end
      bus0.CEOPMODE = 1'b1;
   endtask

   task automatic test_cascade_comb;
      bus1.PCIN = 48'd100; bus1.OPMODE = 5'b00100; bus1.CIN = 1'b0;
      #1;
      checks++; if (bus1.P !== 48'd100) begin errors++; $display("FAIL casc_p got %h exp 64", bus1.P); end
      checks++; if (bus1.PCOUT !== 48'd100) begin errors++; $display("FAIL casc_pcout got %h exp 64", bus1.PCOUT); end
      checks++; if (bus1.CARRYOUT !== 1'b0) begin errors++; $display("FAIL casc_co got %b exp 0", bus1.CARRYOUT); end
      bus1.OPMODE = 5'b01000;
      #1;
      checks++; if (bus1.P !== '0) begin errors++; $display("FAIL nofb_z got %h exp 0", bus1.P); end
      bus1.OPMODE = 5'b00110; bus1.CIN = 1'b1;  // Z=PCIN, X=P(none) + CIN
      #1;
      checks++; if (bus1.P !== 48'd101) begin errors++; $display("FAIL nofb_x got %h exp 65", bus1.P); end
      bus1.OPMODE = 5'b10100;
      #1;
      checks++; if (bus1.P !== 48'd99) begin errors++; $display("FAIL comb_sub got %h exp 63", bus1.P); end
      checks++; if (bus1.CARRYOUT !== 1'b0) begin errors++; $display("FAIL comb_sub_co got %b exp 0", bus1.CARRYOUT); end
      bus1.OPMODE = 5'b10000;
      #1;
      checks++; if (bus1.P !== ONES) begin errors++; $display("FAIL comb_borrow got %h exp %h", bus1.P, ONES); end
      checks++; if (bus1.CARRYOUTF !== 1'b1) begin errors++; $display("FAIL comb_borrowf got %b exp 1", bus1.CARRYOUTF); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_borrow();
      test_accumulate();
      test_opmode_latency();
      test_cascade_comb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
